dc_pred_seq: RTL and testbench
==============================

# dc_pred_seq

Sequential, parametrised DC intra predictor for square blocks from 4x4 up to 2^MAX_LOG2 square. It accepts neighbouring reference samples as a stream of 4-sample beats and stores them. It then computes the DC value with rounding and applies the edge filter on the top row and left column. The prediction is emitted as a raster stream of 4x4 tiles with a valid/ready handshake. It sits between the reference-sample fetch stage and the residual adder, replacing the single-shot 4x4 DC unit.

## Interface
- BIT_DEPTH, 8: sample width in bits (8..12).
- MAX_LOG2, 5: log2 of the largest block size (2..5).
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- LOG2_SIZE  in  3  log2 block size, captured at START; clamped to [2, MAX_LOG2].
- TOP_AVAIL / LEFT_AVAIL  in  1  neighbour availability, captured at START.
- FILTER_EN  in  1  edge-filter enable, captured at START; forced 0 when size is 32.
- REF_VALID  in  1  reference beat valid.
- REF_READY  out  1  block accepts a reference beat.
- REF_DATA  in  4*BIT_DEPTH  four samples; sample 0 in the LSBs and nearest the corner.
- OUT_VALID  out  1  tile valid.
- OUT_READY  in  1  downstream accepts the tile.
- OUT_X / OUT_Y  out  3  tile column and row index.
- PRED  out  16*BIT_DEPTH  tile samples, raster order, sample (0,0) in the LSBs.
- DC_VAL  out  BIT_DEPTH  computed DC, held until the next START.
- BUSY  out  1  high whenever the block is not in IDLE.
- DONE  out  1  one-cycle pulse on the last tile handshake.

## Operation
- States: IDLE, LOAD_TOP, LOAD_LEFT, CALC, EMIT.
- IDLE + START moves to LOAD_TOP if TOP_AVAIL, else to LOAD_LEFT if LEFT_AVAIL, else to CALC.
- LOAD_TOP takes N/4 beats into the top buffer, in order, then moves to LOAD_LEFT (if LEFT_AVAIL) or CALC.
- LOAD_LEFT takes N/4 beats into the left buffer, then moves to CALC.
- A beat transfers on REF_VALID && REF_READY. REF_READY is 1 only in the LOAD states.
- Each accepted beat adds its 4 samples to an accumulator of BIT_DEPTH+MAX_LOG2+1 bits. The accumulator is cleared at START.
- CALC lasts one cycle and registers DC_VAL:
  - both sides available: (sum + N) >> (log2N+1);
  - one side available: (sum + N/2) >> log2N;
  - no side available: 1 << (BIT_DEPTH-1), and filtering is disabled.
- EMIT sends (N/4)^2 tiles in raster order, OUT_X fastest. Interior samples equal DC.
- Filtering, when enabled, uses T[x] and L[y] (block coordinates):
  - corner (0,0) with both sides available: (L[0] + 2*DC + T[0] + 2) >> 2;
  - row 0 with TOP_AVAIL: (T[x] + 3*DC + 2) >> 2, including the corner when only top is available;
  - column 0 with LEFT_AVAIL: (L[y] + 3*DC + 2) >> 2, likewise;
  - edge samples without an available neighbour stay at DC.
- All filter intermediates are BIT_DEPTH+2 bits wide. Results need no clipping.
- START outside IDLE is ignored.
- RST_N low at any point, mid-load or mid-emit, returns the block to IDLE on the next edge; the partial block is discarded.

## Timing
- Reset values:
  - REF_READY, OUT_VALID, BUSY, DONE: 0;
  - OUT_X, OUT_Y, PRED, DC_VAL: 0;
  - buffers and accumulator: 0.
- START is registered in cycle 0 and BUSY=1 from cycle 1.
- Reference beats can transfer from cycle 1 at one beat per cycle. Gaps in REF_VALID only insert stalls.
- With no stalls and both sides available, CALC is in cycle 1+N/2 and the first OUT_VALID is in cycle 2+N/2. For 4x4 the first tile is valid in cycle 4.
- Each tile holds PRED, OUT_X and OUT_Y stable while OUT_VALID && !OUT_READY. The next tile is presented the cycle after a handshake.
- Peak throughput is one tile per cycle.
- DONE is asserted in the cycle of the final handshake. The block is back in IDLE (BUSY=0) the next cycle.
- A START arriving in the cycle after DONE is accepted.

## Test plan
- 4x4, both sides available, FILTER_EN=1, all refs 100: DC_VAL=100 and all 16 samples 100; one tile at (0,0) with DONE on its handshake.
- 4x4, both sides available, FILTER_EN=1, top=8, left=0:
  - DC_VAL=4; sample (0,0)=4;
  - row 0 at x=1..3 = 5; column 0 at y=1..3 = 3; interior = 4.
- 8x8, no side available, BIT_DEPTH=8:
  - no REF_READY ever asserted;
  - CALC in cycle 1 and OUT_VALID in cycle 2;
  - 4 tiles, all samples 128.
- 32x32, FILTER_EN=1, top=50, left=60:
  - filter forced off; DC_VAL=55;
  - 64 tiles, all 55, tiles (0,0)..(7,7) in raster order;
  - DONE on the 64th handshake.
- 16x16, top only, top=200, filter on, with OUT_READY low for 5 cycles on tile 2:
  - DC_VAL=200;
  - PRED/OUT_X/OUT_Y of tile 2 stable through the stall;
  - no tile skipped or duplicated.
- Reset and START handling:
  - RST_N low during LOAD_LEFT: next cycle BUSY=0 and all outputs at reset values;
  - a following 4x4 START completes correctly;
  - START pulsed during EMIT is ignored.

Source files
------------

// File: rtl/dc_pred_seq_if.sv
// dc_pred_seq_if: request, reference-stream and tile-stream signals of the DC predictor.
//   start/log2_size/top_avail/left_avail/filter_en : block request, captured on start
//   ref_valid/ref_ready/ref_data                    : reference beats, 4 samples each
//   out_valid/out_ready/out_x/out_y/pred            : 4x4 prediction tiles, raster order
//   dc_val/busy/done                                : status
// master drives requests and consumes tiles; slave is the predictor.
interface dc_pred_seq_if #(
    parameter int unsigned BIT_DEPTH = 8
);
    logic                      start;
    logic [2:0]                log2_size;
    logic                      top_avail;
    logic                      left_avail;
    logic                      filter_en;
    logic                      ref_valid;
    logic                      ref_ready;
    logic [4*BIT_DEPTH-1:0]    ref_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [2:0]                out_x;
    logic [2:0]                out_y;
    logic [16*BIT_DEPTH-1:0]   pred;
    logic [BIT_DEPTH-1:0]      dc_val;
    logic                      busy;
    logic                      done;

    modport master (
        output start, log2_size, top_avail, left_avail, filter_en, ref_valid, ref_data,
               out_ready,
        input  ref_ready, out_valid, out_x, out_y, pred, dc_val, busy, done
    );

    modport slave (
        input  start, log2_size, top_avail, left_avail, filter_en, ref_valid, ref_data,
               out_ready,
        output ref_ready, out_valid, out_x, out_y, pred, dc_val, busy, done
    );
endinterface

// File: rtl/dc_pred_seq.sv
// dc_pred_seq: sequential DC intra predictor for NxN blocks, N = 4 .. 2^MAX_LOG2.
// Loads top then left reference samples as 4-sample beats, computes the rounded DC,
// then streams the prediction as raster-ordered 4x4 tiles with optional edge filtering.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : dc_pred_seq_if slave (request, reference stream, tile stream, status)
module dc_pred_seq #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned MAX_LOG2  = 5
) (
    input logic          clk,
    input logic          rst_n,
    dc_pred_seq_if.slave bus
);
    localparam int unsigned NMax    = 1 << MAX_LOG2;
    localparam int unsigned AccW    = BIT_DEPTH + MAX_LOG2 + 1;
    localparam int unsigned FltW    = BIT_DEPTH + 2;
    localparam logic [2:0]  MaxLog2 = 3'(MAX_LOG2);

    typedef enum logic [2:0] {StIdle, StLoadTop, StLoadLeft, StCalc, StEmit} state_e;

    state_e               state_q, state_d;
    logic [2:0]           log2_q, log2_d;
    logic                 top_av_q, top_av_d;
    logic                 left_av_q, left_av_d;
    logic                 filt_q, filt_d;
    logic [2:0]           beat_q, beat_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [BIT_DEPTH-1:0] dc_q, dc_d;
    logic [2:0]           tile_x_q, tile_x_d;
    logic [2:0]           tile_y_q, tile_y_d;
    logic [BIT_DEPTH-1:0] top_buf_q [NMax];
    logic [BIT_DEPTH-1:0] top_buf_d [NMax];
    logic [BIT_DEPTH-1:0] left_buf_q [NMax];
    logic [BIT_DEPTH-1:0] left_buf_d [NMax];

    logic [2:0]              log2_in;
    logic [2:0]              last_idx;
    logic [AccW-1:0]         beat_sum;
    logic [AccW-1:0]         n_w;
    logic                    ref_ready, out_valid, ref_hs, out_hs, done;
    logic                    row_f, col_f;
    logic [MAX_LOG2-1:0]     gx, gy;
    logic [FltW-1:0]         dc_w, t_w, l_w, smp;
    logic [16*BIT_DEPTH-1:0] pred;

    assign ref_ready = (state_q == StLoadTop) || (state_q == StLoadLeft);
    assign out_valid = (state_q == StEmit);
    assign ref_hs    = bus.ref_valid && ref_ready;
    assign out_hs    = out_valid && bus.out_ready;
    // Same value serves as last beat index and last tile index: N/4 - 1.
    assign last_idx  = 3'((4'd1 << (log2_q - 3'd2)) - 4'd1);
    assign n_w       = AccW'(1) << log2_q;
    assign row_f     = filt_q && top_av_q;
    assign col_f     = filt_q && left_av_q;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < 4; i++) begin
            beat_sum = beat_sum + AccW'(bus.ref_data[i*BIT_DEPTH +: BIT_DEPTH]);
        end
    end

    always_comb begin
        if (bus.log2_size < 3'd2) begin
            log2_in = 3'd2;
        end else if (bus.log2_size > MaxLog2) begin
            log2_in = MaxLog2;
        end else begin
            log2_in = bus.log2_size;
        end
    end

    always_comb begin
        state_d    = state_q;
        log2_d     = log2_q;
        top_av_d   = top_av_q;
        left_av_d  = left_av_q;
        filt_d     = filt_q;
        beat_d     = beat_q;
        acc_d      = acc_q;
        dc_d       = dc_q;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        top_buf_d  = top_buf_q;
        left_buf_d = left_buf_q;
        done       = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    log2_d    = log2_in;
                    top_av_d  = bus.top_avail;
                    left_av_d = bus.left_avail;
                    // 32x32 blocks are never edge-filtered.
                    filt_d    = bus.filter_en && (log2_in != 3'd5);
                    acc_d     = '0;
                    beat_d    = '0;
                    tile_x_d  = '0;
                    tile_y_d  = '0;
                    if (bus.top_avail) begin
                        state_d = StLoadTop;
                    end else if (bus.left_avail) begin
                        state_d = StLoadLeft;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StLoadTop, StLoadLeft: begin
                if (ref_hs) begin
                    for (int i = 0; i < 4; i++) begin
                        if (state_q == StLoadTop) begin
                            top_buf_d[MAX_LOG2'({beat_q, 2'(i)})] =
                                bus.ref_data[i*BIT_DEPTH +: BIT_DEPTH];
                        end else begin
                            left_buf_d[MAX_LOG2'({beat_q, 2'(i)})] =
                                bus.ref_data[i*BIT_DEPTH +: BIT_DEPTH];
                        end
                    end
                    acc_d = acc_q + beat_sum;
                    if (beat_q == last_idx) begin
                        beat_d  = '0;
                        state_d = (state_q == StLoadTop && left_av_q) ? StLoadLeft : StCalc;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            StCalc: begin
                if (top_av_q && left_av_q) begin
                    dc_d = BIT_DEPTH'((acc_q + n_w) >> (log2_q + 3'd1));
                end else if (top_av_q || left_av_q) begin
                    dc_d = BIT_DEPTH'((acc_q + (n_w >> 1)) >> log2_q);
                end else begin
                    dc_d = {1'b1, {(BIT_DEPTH-1){1'b0}}};
                end
                state_d = StEmit;
            end
            StEmit: begin
                if (out_hs) begin
                    if (tile_x_q == last_idx) begin
                        tile_x_d = '0;
                        if (tile_y_q == last_idx) begin
                            tile_y_d = '0;
                            done     = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            tile_y_d = tile_y_q + 3'd1;
                        end
                    end else begin
                        tile_x_d = tile_x_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Every sample is formed as a 4x-scaled sum then >> 2; unfiltered ones use 4*DC.
    // The top-only corner falls into the row-0 branch, the left-only corner into column 0.
    always_comb begin
        pred = '0;
        gx   = '0;
        gy   = '0;
        t_w  = '0;
        l_w  = '0;
        smp  = '0;
        dc_w = FltW'(dc_q);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                gx  = MAX_LOG2'({tile_x_q, 2'(c)});
                gy  = MAX_LOG2'({tile_y_q, 2'(r)});
                t_w = FltW'(top_buf_q[gx]);
                l_w = FltW'(left_buf_q[gy]);
                if (gx == '0 && gy == '0 && row_f && col_f) begin
                    smp = l_w + (dc_w << 1) + t_w + FltW'(2);
                end else if (gy == '0 && row_f) begin
                    smp = t_w + (dc_w << 1) + dc_w + FltW'(2);
                end else if (gx == '0 && col_f) begin
                    smp = l_w + (dc_w << 1) + dc_w + FltW'(2);
                end else begin
                    smp = dc_w << 2;
                end
                pred[(r*4+c)*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(smp >> 2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            log2_q     <= '0;
            top_av_q   <= 1'b0;
            left_av_q  <= 1'b0;
            filt_q     <= 1'b0;
            beat_q     <= '0;
            acc_q      <= '0;
            dc_q       <= '0;
            tile_x_q   <= '0;
            tile_y_q   <= '0;
            top_buf_q  <= '{default: '0};
            left_buf_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            log2_q     <= log2_d;
            top_av_q   <= top_av_d;
            left_av_q  <= left_av_d;
            filt_q     <= filt_d;
            beat_q     <= beat_d;
            acc_q      <= acc_d;
            dc_q       <= dc_d;
            tile_x_q   <= tile_x_d;
            tile_y_q   <= tile_y_d;
            top_buf_q  <= top_buf_d;
            left_buf_q <= left_buf_d;
        end
    end

    assign bus.ref_ready = ref_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_x     = tile_x_q;
    assign bus.out_y     = tile_y_q;
    assign bus.pred      = pred;
    assign bus.dc_val    = dc_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done;
endmodule

// File: tb/tb_dc_pred_seq.sv
// tb_dc_pred_seq: scenario tasks for dc_pred_seq. A reference model pushes expected tiles
// into a queue when a block is requested; tiles are popped and compared on each handshake.
module tb_dc_pred_seq;
    localparam int unsigned BD = 8;
    localparam int unsigned ML = 5;

    typedef struct {
        logic [2:0]        x;
        logic [2:0]        y;
        logic [16*BD-1:0]  pred;
    } tile_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dc_pred_seq_if #(.BIT_DEPTH(BD)) bus ();

    dc_pred_seq #(.BIT_DEPTH(BD), .MAX_LOG2(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    tests_run = 0;
    int    tests_failed = 0;
    tile_t exp_q[$];
    int    top_v[32];
    int    left_v[32];
    int    exp_dc;
    bit    saw_ref_ready;

    always @(negedge clk) if (bus.ref_ready === 1'b1) saw_ref_ready = 1'b1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: expected DC and every tile of the block, raster order.
    task automatic push_expected(input int l2, input bit ta, input bit la, input bit fe);
        int n = 1 << l2;
        int sum = 0;
        int dc, gx, gy, v;
        bit f;
        tile_t t;
        for (int i = 0; i < n; i++) begin
            if (ta) sum += top_v[i];
            if (la) sum += left_v[i];
        end
        if (ta && la)      dc = (sum + n) >> (l2 + 1);
        else if (ta || la) dc = (sum + n / 2) >> l2;
        else               dc = 1 << (BD - 1);
        exp_dc = dc;
        f = fe && (l2 != 5) && (ta || la);
        for (int ty = 0; ty < n / 4; ty++) begin
            for (int tx = 0; tx < n / 4; tx++) begin
                t.x = 3'(tx);
                t.y = 3'(ty);
                t.pred = '0;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        gx = tx * 4 + c;
                        gy = ty * 4 + r;
                        v = dc;
                        if (f && gx == 0 && gy == 0) begin
                            if (ta && la) v = (left_v[0] + 2 * dc + top_v[0] + 2) >> 2;
                            else if (ta)  v = (top_v[0] + 3 * dc + 2) >> 2;
                            else          v = (left_v[0] + 3 * dc + 2) >> 2;
                        end else if (f && gy == 0 && ta) begin
                            v = (top_v[gx] + 3 * dc + 2) >> 2;
                        end else if (f && gx == 0 && la) begin
                            v = (left_v[gy] + 3 * dc + 2) >> 2;
                        end
                        t.pred[(r*4+c)*BD +: BD] = BD'(v);
                    end
                end
                exp_q.push_back(t);
            end
        end
    endtask

    function automatic logic [4*BD-1:0] pack(input bit is_top, input int b);
        logic [4*BD-1:0] d = '0;
        for (int i = 0; i < 4; i++) begin
            d[i*BD +: BD] = BD'(is_top ? top_v[b*4+i] : left_v[b*4+i]);
        end
        return d;
    endfunction

    // Called right after a rising edge; returns one cycle later with START dropped.
    task automatic do_start(input logic [2:0] l2, input bit ta, input bit la, input bit fe);
        bus.start = 1'b1;
        bus.log2_size = l2;
        bus.top_avail = ta;
        bus.left_avail = la;
        bus.filter_en = fe;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input string name, input logic [4*BD-1:0] d);
        bit acc = 1'b0;
        int k = 0;
        bus.ref_valid = 1'b1;
        bus.ref_data = d;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = bus.ref_ready;
            @(posedge clk); #1;
            k++;
        end
        bus.ref_valid = 1'b0;
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s ref_beat: ref_ready got 0 for %0d cycles, need 1", name, k);
        end
    endtask

    task automatic send_beats(input string name, input int l2, input bit ta, input bit la);
        int nb = (1 << l2) / 4;
        if (ta) for (int b = 0; b < nb; b++) send_beat(name, pack(1'b1, b));
        if (la) for (int b = 0; b < nb; b++) send_beat(name, pack(1'b0, b));
    endtask

    // Drains the expected queue against the tile stream; optionally stalls one tile or
    // pulses START during emission. first_wait is cycles until the first OUT_VALID.
    task automatic collect(input string name, input int stall_tile, input int stall_len,
                           input int pulse_tile, output int first_wait);
        tile_t e;
        int idx = 0;
        int cyc = 0;
        int st = 0;
        bit seen = 1'b0;
        bit pulsed = 1'b0;
        first_wait = -1;
        while (exp_q.size() > 0 && cyc < 2000) begin
            bus.out_ready = !(idx == stall_tile && st < stall_len);
            if (idx == pulse_tile && !pulsed) begin
                bus.start = 1'b1;
                bus.log2_size = 3'd0;
                bus.top_avail = 1'b0;
                bus.left_avail = 1'b0;
                pulsed = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    first_wait = cyc;
                end
                e = exp_q[0];
                tests_run++;
                if (bus.out_x !== e.x || bus.out_y !== e.y) begin
                    tests_failed++;
                    $display("FAIL %s tile_xy idx %0d: got (%0d,%0d) need (%0d,%0d)",
                             name, idx, bus.out_x, bus.out_y, e.x, e.y);
                end
                tests_run++;
                if (bus.pred !== e.pred) begin
                    tests_failed++;
                    $display("FAIL %s pred idx %0d: got %h need %h", name, idx, bus.pred, e.pred);
                end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    tests_run++;
                    if (bus.done !== (exp_q.size() == 0)) begin
                        tests_failed++;
                        $display("FAIL %s done idx %0d: got %b need %b", name, idx, bus.done,
                                 exp_q.size() == 0);
                    end
                    idx++;
                end else begin
                    st++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s tile_count: %0d tiles still expected after %0d cycles",
                     name, exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.ref_ready, bus.out_valid, bus.done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset flags busy/ref_ready/out_valid/done: got %b need 0000",
                     {bus.busy, bus.ref_ready, bus.out_valid, bus.done});
        end
        tests_run++;
        if (bus.out_x !== 3'd0 || bus.out_y !== 3'd0 || bus.dc_val !== '0) begin
            tests_failed++;
            $display("FAIL reset x/y/dc: got %0d %0d %0d need 0 0 0", bus.out_x, bus.out_y,
                     bus.dc_val);
        end
        tests_run++;
        if (bus.pred !== '0) begin
            tests_failed++;
            $display("FAIL reset pred: got %h need 0", bus.pred);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_flat_4x4();
        int fw;
        for (int i = 0; i < 32; i++) begin
            top_v[i] = 100;
            left_v[i] = 100;
        end
        push_expected(2, 1, 1, 1);
        do_start(3'd2, 1, 1, 1);
        send_beats("flat4", 2, 1, 1);
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL flat4 calc_cycle3: out_valid/busy got %b%b need 01", bus.out_valid,
                     bus.busy);
        end
        @(posedge clk); #1;
        collect("flat4", -1, 0, -1, fw);
        tests_run++;
        if (fw !== 0) begin
            tests_failed++;
            $display("FAIL flat4 first_valid: got wait %0d need 0 (cycle 4)", fw);
        end
        tests_run++;
        if (bus.dc_val !== 8'd100) begin
            tests_failed++;
            $display("FAIL flat4 dc_val: got %0d need 100", bus.dc_val);
        end
    endtask

    task automatic test_filter_4x4();
        int fw;
        for (int i = 0; i < 32; i++) begin
            top_v[i] = 8;
            left_v[i] = 0;
        end
        push_expected(2, 1, 1, 1);
        do_start(3'd2, 1, 1, 1);
        send_beats("filt4", 2, 1, 1);
        collect("filt4", -1, 0, -1, fw);
        tests_run++;
        if (bus.dc_val !== 8'd4) begin
            tests_failed++;
            $display("FAIL filt4 dc_val: got %0d need 4", bus.dc_val);
        end
    endtask

    task automatic test_no_side();
        int fw;
        saw_ref_ready = 1'b0;
        push_expected(3, 0, 0, 1);
        do_start(3'd3, 0, 0, 1);
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL noside calc_cycle1: out_valid/busy got %b%b need 01", bus.out_valid,
                     bus.busy);
        end
        @(posedge clk); #1;
        collect("noside", -1, 0, -1, fw);
        tests_run++;
        if (fw !== 0) begin
            tests_failed++;
            $display("FAIL noside first_valid: got wait %0d need 0 (cycle 2)", fw);
        end
        tests_run++;
        if (saw_ref_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL noside ref_ready: got asserted need never");
        end
        tests_run++;
        if (bus.dc_val !== 8'd128) begin
            tests_failed++;
            $display("FAIL noside dc_val: got %0d need 128", bus.dc_val);
        end
    endtask

    task automatic test_32x32();
        int fw;
        for (int i = 0; i < 32; i++) begin
            top_v[i] = 50;
            left_v[i] = 60;
        end
        push_expected(5, 1, 1, 1);
        do_start(3'd5, 1, 1, 1);
        send_beats("blk32", 5, 1, 1);
        collect("blk32", -1, 0, -1, fw);
        tests_run++;
        if (bus.dc_val !== 8'd55) begin
            tests_failed++;
            $display("FAIL blk32 dc_val: got %0d need 55", bus.dc_val);
        end
    endtask

    task automatic test_stall();
        int fw;
        for (int i = 0; i < 32; i++) begin
            top_v[i] = 200;
            left_v[i] = 0;
        end
        push_expected(4, 1, 0, 1);
        do_start(3'd4, 1, 0, 1);
        send_beats("stall16", 4, 1, 0);
        collect("stall16", 2, 5, -1, fw);
        tests_run++;
        if (bus.dc_val !== 8'd200) begin
            tests_failed++;
            $display("FAIL stall16 dc_val: got %0d need 200", bus.dc_val);
        end
    endtask

    task automatic test_reset_midload();
        int fw;
        for (int i = 0; i < 4; i++) begin
            top_v[i] = 10 + i * 20;
            left_v[i] = 200 - i * 20;
        end
        do_start(3'd2, 1, 1, 1);
        send_beat("rstmid", pack(1'b1, 0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.ref_ready, bus.out_valid, bus.done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstmid flags busy/ref_ready/out_valid/done: got %b need 0000",
                     {bus.busy, bus.ref_ready, bus.out_valid, bus.done});
        end
        tests_run++;
        if (bus.dc_val !== '0 || bus.pred !== '0 || bus.out_x !== 3'd0 || bus.out_y !== 3'd0) begin
            tests_failed++;
            $display("FAIL rstmid data: got dc %0d pred %h xy (%0d,%0d) need all 0",
                     bus.dc_val, bus.pred, bus.out_x, bus.out_y);
        end
        @(posedge clk); #1;
        push_expected(2, 1, 1, 1);
        do_start(3'd2, 1, 1, 1);
        send_beats("rstmid", 2, 1, 1);
        collect("rstmid", -1, 0, -1, fw);
        tests_run++;
        if (bus.dc_val !== BD'(exp_dc)) begin
            tests_failed++;
            $display("FAIL rstmid dc_val: got %0d need %0d", bus.dc_val, exp_dc);
        end
    endtask

    task automatic test_back_to_back();
        int fw;
        for (int i = 0; i < 8; i++) begin
            top_v[i] = (i * 37 + 11) % 256;
            left_v[i] = 255 - i * 23;
        end
        push_expected(3, 1, 1, 1);
        do_start(3'd3, 1, 1, 1);
        send_beats("b2b", 3, 1, 1);
        collect("b2b", -1, 0, 1, fw);
        // Cycle after DONE: idle, and a new START here must be taken.
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b idle_after_done: busy got %b need 0", bus.busy);
        end
        for (int i = 0; i < 4; i++) left_v[i] = 90 + i * 3;
        push_expected(2, 0, 1, 1);
        do_start(3'd0, 0, 1, 1);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.ref_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b restart: busy/ref_ready got %b%b need 11", bus.busy,
                     bus.ref_ready);
        end
        send_beats("b2b_clamp", 2, 0, 1);
        collect("b2b_clamp", -1, 0, -1, fw);
        tests_run++;
        if (bus.dc_val !== BD'(exp_dc)) begin
            tests_failed++;
            $display("FAIL b2b_clamp dc_val: got %0d need %0d", bus.dc_val, exp_dc);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.log2_size = 3'd0;
        bus.top_avail = 1'b0;
        bus.left_avail = 1'b0;
        bus.filter_en = 1'b0;
        bus.ref_valid = 1'b0;
        bus.ref_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_flat_4x4();
        test_filter_4x4();
        test_no_side();
        test_32x32();
        test_stall();
        test_reset_midload();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
